// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: one outstanding memory request, a small FIFO of
// fetched {pc, instr} pairs toward ID, and redirect handling with stale-response drain.
module ysyx_22041412_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic [63:0]   buf_pc_q    [DEPTH];
  logic [63:0]   buf_pc_d    [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:0]   buf_instr_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic req_fire, push, pop, pending_after;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign push     = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop      = out_valid && out_ready && !redirect_valid;
  // A request is still in flight after this edge if one was just accepted,
  // or one was outstanding and its response has not arrived this cycle.
  assign pending_after = req_fire || ((state_q != S_RUN) && !imem_rsp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = pending_after ? S_DRAIN : S_RUN;
    end else begin
      case (state_q)
        S_RUN:           if (req_fire)       state_d = S_WAIT;
        S_WAIT, S_DRAIN: if (imem_rsp_valid) state_d = S_RUN;
        default:                             state_d = S_RUN;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    if (!rst && (state_q == S_RUN) && (count_q < DEPTH_C)) imem_req_valid = 1'b1;
    imem_req_addr = fetch_pc_q;
    out_valid     = (count_q != '0);
    out_pc        = buf_pc_q[head_q];
    out_instr     = buf_instr_q[head_q];
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~64'h3;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (req_fire) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      if (push) begin
        buf_pc_d[tail_q]    = req_pc_q;
        buf_instr_d[tail_q] = imem_rsp_data;
        tail_d              = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Bench for ysyx_22041412_ifu: vector table, directed corner sequences, and a
// randomized run against a queue-based transaction model with a modelled memory.
module tb_ysyx_22041412_ifu;

  localparam logic [63:0] RST_PC  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          DEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_ready, imem_rsp_valid, redirect_valid, out_ready;
  logic [31:0] imem_rsp_data;
  logic [63:0] redirect_pc;

  logic        req_valid, o_valid, w_req_valid, w_out_valid;
  logic [63:0] req_addr, o_pc, w_req_addr, w_out_pc;
  logic [31:0] o_instr, w_out_instr;

  int checks = 0;
  int failures = 0;

  ysyx_22041412_ifu #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(o_valid), .out_ready(out_ready), .out_pc(o_pc), .out_instr(o_instr)
  );

  ysyx_22041412_ifu #(.RESET_PC(WRAP_PC), .DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc), .out_instr(w_out_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ordy;
    logic        exp_rv;
    logic [63:0] exp_addr;
    logic        exp_ov;
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs, then wait to the falling edge for sampling.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic redir, input logic [63:0] rpc, input logic ordy);
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = ordy;
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("reset req_valid", {63'b0, req_valid}, 64'd0);
    checkOutput("reset out_valid", {63'b0, o_valid}, 64'd0);
    checkOutput("reset out_pc", o_pc, 64'd0);
    checkOutput("reset out_instr", {32'b0, o_instr}, 64'd0);
    checkOutput("reset req_addr", req_addr, RST_PC);
    checkOutput("reset wrap req_addr", w_req_addr, WRAP_PC);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    logic [63:0] q_pc[$];
    logic [31:0] q_in[$];
    bit          outst, stale, pend, fire, exp_rv, rdy, rv, redir, ordy;
    logic [63:0] opc, next_fetch, paddr, rpc, fire_addr;
    logic [31:0] rd;
    int          dly;

    vecs[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0,          32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0010_0093, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0,          32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000, 32'h0010_0093};
    vecs[3] = '{1'b1, 1'b1, 32'h0020_0113, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0,          32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004, 32'h0020_0113};
    vecs[5] = '{1'b1, 1'b1, 32'h0030_0193, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0,          32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008, 32'h0030_0193};

    // Streaming fetch with an always-ready memory and consumer.
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].rdy, vecs[i].rv, vecs[i].rd, 1'b0, 64'h0, vecs[i].ordy);
      checkOutput($sformatf("vec%0d req_valid", i), {63'b0, req_valid}, {63'b0, vecs[i].exp_rv});
      if (vecs[i].exp_rv) checkOutput($sformatf("vec%0d req_addr", i), req_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d out_valid", i), {63'b0, o_valid}, {63'b0, vecs[i].exp_ov});
      if (vecs[i].exp_ov) begin
        checkOutput($sformatf("vec%0d out_pc", i), o_pc, vecs[i].exp_pc);
        checkOutput($sformatf("vec%0d out_instr", i), {32'b0, o_instr}, {32'b0, vecs[i].exp_instr});
      end
      nextCycle();
    end

    // Consumer stalled: buffer fills to DEPTH and fetching stops.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0); nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h1111_0001, 1'b0, 64'h0, 1'b0); nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("fill req_addr 2nd", req_addr, 64'h8000_0004);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h1111_0002, 1'b0, 64'h0, 1'b0); nextCycle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
      checkOutput("full req_valid", {63'b0, req_valid}, 64'd0);
      checkOutput("full out_valid", {63'b0, o_valid}, 64'd1);
      checkOutput("full out_pc", o_pc, 64'h8000_0000);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    checkOutput("full head instr", {32'b0, o_instr}, 64'h1111_0001);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("after pop out_pc", o_pc, 64'h8000_0004);
    checkOutput("after pop out_instr", {32'b0, o_instr}, 64'h1111_0002);
    checkOutput("after pop req_valid", {63'b0, req_valid}, 64'd1);
    checkOutput("after pop req_addr", req_addr, 64'h8000_0008);
    nextCycle();

    // Redirect while waiting: stale response dropped, target aligned.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0); nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 64'h8000_0103, 1'b0);
    checkOutput("redir wait req_valid", {63'b0, req_valid}, 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0, 1'b0);
    checkOutput("drain req_valid", {63'b0, req_valid}, 64'd0);
    checkOutput("drain out_valid", {63'b0, o_valid}, 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("post drain req_valid", {63'b0, req_valid}, 64'd1);
    checkOutput("post drain req_addr", req_addr, 64'h8000_0100);
    checkOutput("post drain out_valid", {63'b0, o_valid}, 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h2222_0003, 1'b0, 64'h0, 1'b0); nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("redir target out_pc", o_pc, 64'h8000_0100);
    checkOutput("redir target out_instr", {32'b0, o_instr}, 64'h2222_0003);
    nextCycle();

    // Redirect coinciding with a response and an output handshake.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0); nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h3333_0001, 1'b0, 64'h0, 1'b0); nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("pre redir out_valid", {63'b0, o_valid}, 64'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h3333_0002, 1'b1, 64'h8000_2002, 1'b1); nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("flush out_valid", {63'b0, o_valid}, 64'd0);
    checkOutput("flush req_valid", {63'b0, req_valid}, 64'd1);
    checkOutput("flush req_addr", req_addr, 64'h8000_2000);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h3333_0003, 1'b0, 64'h0, 1'b0); nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("flush next out_pc", o_pc, 64'h8000_2000);
    checkOutput("flush next out_instr", {32'b0, o_instr}, 64'h3333_0003);
    nextCycle();

    // Fetch PC wraps past the top of the address space.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("wrap req_valid", {63'b0, w_req_valid}, 64'd1);
    checkOutput("wrap req_addr 1st", w_req_addr, WRAP_PC);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h4444_0001, 1'b0, 64'h0, 1'b0); nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("wrap req_addr 2nd", w_req_addr, 64'h0);
    checkOutput("wrap out_valid", {63'b0, w_out_valid}, 64'd1);
    checkOutput("wrap out_pc", w_out_pc, WRAP_PC);
    checkOutput("wrap out_instr", {32'b0, w_out_instr}, 64'h4444_0001);
    nextCycle();

    // Reset while waiting, then a late response after release.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0); nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h5555_0001, 1'b0, 64'h0, 1'b0); nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0); nextCycle();
    doReset();
    applyStimulus(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 64'h0, 1'b0);
    checkOutput("late rsp req_valid", {63'b0, req_valid}, 64'd1);
    checkOutput("late rsp req_addr", req_addr, RST_PC);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("late rsp dropped", {63'b0, o_valid}, 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h5555_0002, 1'b0, 64'h0, 1'b0); nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("post reset out_pc", o_pc, RST_PC);
    checkOutput("post reset out_instr", {32'b0, o_instr}, 64'h5555_0002);
    nextCycle();

    // Randomized traffic against the transaction model.
    doReset();
    q_pc.delete();
    q_in.delete();
    outst = 1'b0; stale = 1'b0; pend = 1'b0; dly = 0;
    opc = '0; paddr = '0; next_fetch = RST_PC;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if (pend && dly == 0) begin
        rv = 1'b1; rd = mem_word(paddr);
      end else begin
        rv = (!pend && $urandom_range(0, 7) == 0);
        rd = $urandom;
      end
      redir = ($urandom_range(0, 19) == 0);
      rpc   = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
      ordy  = ((cyc % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      applyStimulus(rdy, rv, rd, redir, rpc, ordy);

      exp_rv = !outst && (q_pc.size() < DEPTH);
      checkOutput("rnd req_valid", {63'b0, req_valid}, {63'b0, exp_rv});
      if (exp_rv) checkOutput("rnd req_addr", req_addr, next_fetch);
      checkOutput("rnd out_valid", {63'b0, o_valid}, {63'b0, q_pc.size() > 0});
      if (q_pc.size() > 0) begin
        checkOutput("rnd out_pc", o_pc, q_pc[0]);
        checkOutput("rnd out_instr", {32'b0, o_instr}, {32'b0, q_in[0]});
      end

      fire      = exp_rv && rdy;
      fire_addr = next_fetch;
      if (redir) begin
        q_pc.delete();
        q_in.delete();
        next_fetch = rpc & ~64'h3;
        outst      = (outst && !rv) || fire;
        stale      = outst;
      end else begin
        if (q_pc.size() > 0 && ordy) begin
          void'(q_pc.pop_front());
          void'(q_in.pop_front());
        end
        if (outst && rv) begin
          if (!stale) begin
            q_pc.push_back(opc);
            q_in.push_back(rd);
          end
          outst = 1'b0;
        end else if (fire) begin
          outst      = 1'b1;
          stale      = 1'b0;
          opc        = fire_addr;
          next_fetch = fire_addr + 64'd4;
        end
      end

      if (pend && dly == 0 && rv) pend = 1'b0;
      else if (pend) dly--;
      if (fire) begin
        pend  = 1'b1;
        paddr = fire_addr;
        dly   = $urandom_range(0, 2);
      end
      nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_ifu.md
YSYX_22041412_IFU -- requirements
Module: ysyx_22041412_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: instruction buffer entries; legal values are 2 or 4.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1 bit: instruction memory accepts the request.
REQ-007 SHALL have port imem_req_addr, output, 64 bits: fetch address, word-aligned.
REQ-008 SHALL have port imem_rsp_valid, input, 1 bit: instruction word returned.
REQ-009 SHALL have port imem_rsp_data, input, 32 bits: instruction word.
REQ-010 SHALL have port redirect_valid, input, 1 bit: control-flow change from the EXE/WB stage (jal, branch taken).
REQ-011 SHALL have port redirect_pc, input, 64 bits: new fetch target.
REQ-012 SHALL have port out_valid, output, 1 bit: buffer head valid toward ID.
REQ-013 SHALL have port out_ready, input, 1 bit: ID accepts the head.
REQ-014 SHALL have port out_pc, output, 64 bits: PC of the head instruction.
REQ-015 SHALL have port out_instr, output, 32 bits: head instruction word.

Function
REQ-016 SHALL implement a 3-state FSM: RUN (no request outstanding), WAIT (one request accepted, response pending), DRAIN (stale response pending after a redirect).
REQ-017 SHALL assert imem_req_valid only in RUN, and only when buffer count plus outstanding requests < DEPTH; at most one request SHALL be outstanding.
REQ-018 SHALL, on a request handshake (valid and ready), move to WAIT and advance fetch_pc by 4, using 64-bit modulo arithmetic (all-ones-minus-3 wraps to 0).
REQ-019 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0, except on a redirect.
REQ-020 SHALL, on imem_rsp_valid in WAIT, push {request PC, imem_rsp_data} into the buffer in that cycle and return to RUN; a new request is allowed in the following cycle, not the same one.
REQ-021 SHALL ignore imem_rsp_valid in RUN.
REQ-022 SHALL, on imem_rsp_valid in DRAIN, discard the data and go to RUN.
REQ-023 SHALL drive out_valid whenever the buffer is not empty; out_pc and out_instr SHALL be the head entry and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 SHALL pop the head on out_valid and out_ready; a simultaneous push and pop SHALL leave the count unchanged, and order SHALL be strict FIFO.
REQ-025 SHALL, on redirect_valid, in the same edge: flush the buffer (out_valid=0 next cycle), set fetch_pc to redirect_pc with bits [1:0] forced to 0, and enter DRAIN if a request is outstanding or is accepted that cycle, else RUN.
REQ-026 SHALL give redirect priority over response push and output pop in the same cycle; the downstream stage treats any output handshake in the redirect cycle as flushed.
REQ-027 SHALL, when redirected in DRAIN, stay in DRAIN with the newest redirect_pc as fetch_pc.
REQ-028 SHALL give a minimum latency of 2 cycles from request acceptance to out_valid: 1 cycle for the memory response and 1 cycle for the buffer register.

Reset
REQ-029 SHALL, while rst=1, asynchronously force: state=RUN, buffer empty, out_valid=0, out_pc=0, out_instr=0, imem_req_valid=0, fetch_pc=RESET_PC.
REQ-030 SHALL assert imem_req_valid with imem_req_addr=RESET_PC in the first cycle after rst deasserts.
REQ-031 SHALL, on reset during WAIT or DRAIN, discard any outstanding response arriving after reset release.

Verification
REQ-032 Bench SHALL cover: reset release, memory always ready, 1-cycle response, out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008 with matching instr; first out_valid 2 cycles after first accept.
REQ-033 Bench SHALL cover: out_ready=0 with DEPTH=2 -> exactly 2 entries buffered, imem_req_valid then held 0, out_pc held 0x80000000 until out_ready=1.
REQ-034 Bench SHALL cover: redirect_valid with redirect_pc=0x80000103 while in WAIT -> stale response dropped, next imem_req_addr=0x80000100, buffer empty next cycle.
REQ-035 Bench SHALL cover: redirect in the same cycle as imem_rsp_valid and out_ready=1 -> no push, buffer flushed, next fetch from redirect_pc.
REQ-036 Bench SHALL cover: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second request address is 0.
REQ-037 Bench SHALL cover: rst pulse in WAIT followed by a late imem_rsp_valid -> response ignored, first out_pc=RESET_PC.
